// File: rtl/spikes_reshape_pkg.sv
// Shared constants, width helpers and push classification for the spike row reshaper.
// Every reshaper file imports this package.
package spikes_reshape_pkg;

    localparam int DEF_TIME_STEPS     = 32'sd4;
    localparam int DEF_UNIT_NUM       = 32'sd16;
    localparam int DEF_LINES_PER_ROW  = 32'sd2;
    localparam int DEF_ROW_FIFO_DEPTH = 32'sd4;
    localparam int DEF_NUM_CH         = 32'sd3;

    typedef enum logic [1:0] {
        PUSH_NONE  = 2'd0,
        PUSH_FULL  = 2'd1,
        PUSH_FLUSH = 2'd2,
        PUSH_PEND  = 2'd3
    } push_kind_e;

    function automatic int safe_clog2(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int line_w(input int unit_num, input int time_steps);
        return unit_num * time_steps;
    endfunction

    function automatic int row_w(input int lines_per_row, input int unit_num, input int time_steps);
        return lines_per_row * line_w(unit_num, time_steps);
    endfunction

endpackage

// File: rtl/spikes_reshape_lane.sv
// One channel of the reshaper: word/line counters, row assembly register,
// flush handling and a first-word-fall-through FIFO of completed rows.
module spikes_reshape_lane
    import spikes_reshape_pkg::*;
#(
    parameter int TIME_STEPS     = DEF_TIME_STEPS,
    parameter int UNIT_NUM       = DEF_UNIT_NUM,
    parameter int LINES_PER_ROW  = DEF_LINES_PER_ROW,
    parameter int ROW_FIFO_DEPTH = DEF_ROW_FIFO_DEPTH,
    parameter int ROW_W          = row_w(LINES_PER_ROW, UNIT_NUM, TIME_STEPS)
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic [TIME_STEPS-1:0] i_word,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_flush,
    output logic [ROW_W-1:0]      o_row_data,
    output logic                  o_row_valid,
    input  logic                  i_row_ready,
    output logic                  o_row_partial,
    output logic                  o_overflow
);

    localparam int WC_W   = safe_clog2(UNIT_NUM);
    localparam int LC_W   = safe_clog2(LINES_PER_ROW);
    localparam int SLOT_W = WC_W + LC_W;
    localparam int SLOTS  = UNIT_NUM * LINES_PER_ROW;
    localparam int PTR_W  = safe_clog2(ROW_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = ROW_W + 1;

    logic [WC_W-1:0]  r_word_cnt;
    logic [LC_W-1:0]  r_line_cnt;
    logic [ROW_W-1:0] r_asm;
    logic             r_pend;
    logic             r_ovf;
    logic [ENT_W-1:0] r_mem [ROW_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_accept;
    logic              w_held;
    logic              w_last_word;
    logic              w_last_line;
    logic              w_complete;
    logic [SLOT_W-1:0] w_slot;
    logic [ROW_W-1:0]  w_base;
    logic [ROW_W-1:0]  w_row_next;
    logic              w_flush_now;
    logic              w_pend_set;
    push_kind_e        w_push_kind;
    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;

    assign w_full      = (r_count == CNT_W'(ROW_FIFO_DEPTH));
    assign w_empty     = (r_count == CNT_W'(0));
    assign w_ready     = ~w_full & ~r_pend;
    assign w_accept    = i_valid & w_ready;
    assign w_held      = (r_word_cnt != WC_W'(0)) | (r_line_cnt != LC_W'(0));
    assign w_last_word = (r_word_cnt == WC_W'(UNIT_NUM - 1));
    assign w_last_line = (r_line_cnt == LC_W'(LINES_PER_ROW - 1));
    assign w_complete  = w_accept & w_last_word & w_last_line;
    assign w_slot      = {r_line_cnt, r_word_cnt};
    // A new row starts from a clean slate so no stale words survive into it.
    assign w_base      = w_held ? r_asm : {ROW_W{1'b0}};
    assign w_flush_now = i_flush & ~r_pend & (w_held | w_accept) & ~w_complete;
    assign w_pend_set  = w_flush_now & w_full;
    assign w_push      = (w_push_kind != PUSH_NONE);
    assign w_pop       = ~w_empty & i_row_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Merge the accepted word into its slot of the row being assembled.
    always_comb begin
        w_row_next = w_base;
        for (int k = 0; k < SLOTS; k++) begin
            w_row_next[k*TIME_STEPS +: TIME_STEPS] =
                (w_accept && (w_slot == SLOT_W'(k))) ? i_word : w_base[k*TIME_STEPS +: TIME_STEPS];
        end
    end

    // Classify what, if anything, is pushed into the row FIFO this cycle.
    always_comb begin
        w_push_kind = PUSH_NONE;
        if (r_pend && !w_full) begin
            w_push_kind = PUSH_PEND;
        end else if (w_complete) begin
            w_push_kind = PUSH_FULL;
        end else if (w_flush_now && !w_full) begin
            w_push_kind = PUSH_FLUSH;
        end else begin
            w_push_kind = PUSH_NONE;
        end
    end

    // Word/line counters and the assembly register.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_word_cnt <= WC_W'(0);
            r_line_cnt <= LC_W'(0);
            r_asm      <= {ROW_W{1'b0}};
        end else begin
            case (w_push_kind)
                PUSH_FLUSH, PUSH_PEND: begin
                    r_word_cnt <= WC_W'(0);
                    r_line_cnt <= LC_W'(0);
                end
                default: begin
                    if (w_accept) begin
                        r_word_cnt <= w_last_word ? WC_W'(0) : r_word_cnt + WC_W'(1);
                        if (w_last_word) begin
                            r_line_cnt <= w_last_line ? LC_W'(0) : r_line_cnt + LC_W'(1);
                        end else begin
                            r_line_cnt <= r_line_cnt;
                        end
                    end else begin
                        r_word_cnt <= r_word_cnt;
                        r_line_cnt <= r_line_cnt;
                    end
                end
            endcase
            r_asm <= w_accept ? w_row_next : r_asm;
        end
    end

    // Deferred flush request and sticky overflow flag.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_pend_set) begin
                r_pend <= 1'b1;
            end else if (w_push_kind == PUSH_PEND) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
            r_ovf <= r_ovf | (i_valid & ~w_ready);
        end
    end

    // Row FIFO storage and pointers; a push never targets a full FIFO.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int i = 0; i < ROW_FIFO_DEPTH; i++) begin
                r_mem[i] <= {ENT_W{1'b0}};
            end
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {(w_push_kind != PUSH_FULL), w_row_next};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            r_rd_ptr <= w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_ready       = w_ready;
    assign o_row_valid   = ~w_empty;
    assign o_row_data    = w_empty ? {ROW_W{1'b0}} : w_head[ROW_W-1:0];
    assign o_row_partial = ~w_empty & w_head[ROW_W];
    assign o_overflow    = r_ovf;

endmodule

// File: rtl/spikes_reshape_array.sv
// Multi-channel spike reshaper: one independent lane per channel, with the
// flat word and row buses sliced per channel.
module spikes_reshape_array
    import spikes_reshape_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int TIME_STEPS     = DEF_TIME_STEPS,
    parameter int UNIT_NUM       = DEF_UNIT_NUM,
    parameter int LINES_PER_ROW  = DEF_LINES_PER_ROW,
    parameter int ROW_FIFO_DEPTH = DEF_ROW_FIFO_DEPTH,
    parameter int ROW_W          = row_w(LINES_PER_ROW, UNIT_NUM, TIME_STEPS)
) (
    input  logic                         s_clk,
    input  logic                         s_rst_n,
    input  logic [NUM_CH*TIME_STEPS-1:0] i_spikes,
    input  logic [NUM_CH-1:0]            i_spikes_valid,
    output logic [NUM_CH-1:0]            o_spikes_ready,
    input  logic [NUM_CH-1:0]            i_flush,
    output logic [NUM_CH*ROW_W-1:0]      o_row_data,
    output logic [NUM_CH-1:0]            o_row_valid,
    input  logic [NUM_CH-1:0]            i_row_ready,
    output logic [NUM_CH-1:0]            o_row_partial,
    output logic [NUM_CH-1:0]            o_overflow
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        spikes_reshape_lane #(
            .TIME_STEPS     (TIME_STEPS),
            .UNIT_NUM       (UNIT_NUM),
            .LINES_PER_ROW  (LINES_PER_ROW),
            .ROW_FIFO_DEPTH (ROW_FIFO_DEPTH),
            .ROW_W          (ROW_W)
        ) u_lane (
            .s_clk         (s_clk),
            .s_rst_n       (s_rst_n),
            .i_word        (i_spikes[c*TIME_STEPS +: TIME_STEPS]),
            .i_valid       (i_spikes_valid[c]),
            .o_ready       (o_spikes_ready[c]),
            .i_flush       (i_flush[c]),
            .o_row_data    (o_row_data[c*ROW_W +: ROW_W]),
            .o_row_valid   (o_row_valid[c]),
            .i_row_ready   (i_row_ready[c]),
            .o_row_partial (o_row_partial[c]),
            .o_overflow    (o_overflow[c])
        );
    end

endmodule
